// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time the right to
// push up to `burst` words into a FIFO, stalling on wfull.
module fifo_wr_arbiter #(
  parameter int dw    = 8,
  parameter int nreq  = 4,
  parameter int burst = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [nreq-1:0]    req,
  input  logic [nreq*dw-1:0] req_data,
  output logic [nreq-1:0]    ack,
  output logic [nreq-1:0]    gnt,
  input  logic               wfull,
  output logic               winc,
  output logic [dw-1:0]      wdata
);

  localparam int pw = $clog2(nreq);
  localparam int cw = $clog2(burst + 1);
  localparam logic [cw-1:0] last = cw'(burst - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [pw-1:0]   rr_ptr;
  logic [cw-1:0]   cnt;

  logic [nreq-1:0] pick;
  logic [pw-1:0]   idx;
  logic [pw-1:0]   next_ptr;
  logic            found;
  logic            own_req;
  logic [dw-1:0]   own_data;

  // Round-robin pick: first asserted request at or above rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    next_ptr = rr_ptr;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < nreq; k++) begin
      idx = pw'((int'(rr_ptr) + k) % nreq);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        next_ptr  = pw'((int'(idx) + 1) % nreq);
      end
    end
  end

  // Owner request/data mux, selected by the one-hot grant register.
  always_comb begin
    own_req  = |(req & gnt);
    own_data = '0;
    for (int i = 0; i < nreq; i++)
      if (gnt[i]) own_data = own_data | req_data[i*dw +: dw];
  end

  // Transfer side is combinational off registered state, so reset clears it
  // immediately and a full FIFO blocks the write in the same cycle.
  assign winc  = (state == XFER) & own_req & ~wfull;
  assign ack   = gnt & {nreq{winc}};
  assign wdata = winc ? own_data : '0;

  // Grant FSM: IDLE picks an owner (one bubble cycle), XFER moves words
  // until the burst is used up or the owner stops requesting.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= pick;
            rr_ptr <= next_ptr;
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if ((winc && cnt == last) || !own_req) begin
            gnt   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (winc) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter (nreq=4, burst=4), plus a
// burst=1 instance sharing the same inputs.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        wfull = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack, gnt, ack1, gnt1;
  logic        winc, winc1;
  logic [7:0]  wdata, wdata1;

  int checks = 0;
  int errors = 0;
  int words  = 0;
  int seq [4];
  logic [7:0] expq [4][$];

  logic [3:0] o_gnt, o_ack, o_gnt1, o_ack1;
  logic       o_winc, o_winc1;
  logic [7:0] o_wdata, o_wdata1, o_front0;

  fifo_wr_arbiter #(.dw(8), .nreq(4), .burst(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .ack(ack), .gnt(gnt), .wfull(wfull), .winc(winc), .wdata(wdata));

  fifo_wr_arbiter #(.dw(8), .nreq(4), .burst(1)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .ack(ack1), .gnt(gnt1), .wfull(wfull), .winc(winc1), .wdata(wdata1));

  always #5 wclk = ~wclk;

  function automatic logic [7:0] word_of(int i);
    return 8'(i * 64 + seq[i] % 64);
  endfunction

  // Present requester i's next word and record it as expected.
  task automatic present(int i);
    req_data[i*8 +: 8] = word_of(i);
    expq[i].push_back(word_of(i));
  endtask

  // One clock: sample at negedge, score accepted word, advance data after edge.
  task automatic cyc();
    int hit;
    logic [7:0] exp_w;
    hit = -1;
    @(negedge wclk);
    o_gnt = gnt; o_ack = ack; o_winc = winc; o_wdata = wdata;
    o_gnt1 = gnt1; o_ack1 = ack1; o_winc1 = winc1; o_wdata1 = wdata1;
    o_front0 = req_data[7:0];
    checks++;
    if (winc & wfull) begin
      errors++; $display("FAIL winc_while_full winc=%b wfull=%b", winc, wfull);
    end
    checks++;
    if (!winc && wdata !== 8'h00) begin
      errors++; $display("FAIL idle_wdata wdata=%h exp=00", wdata);
    end
    if (winc) begin
      words++;
      for (int i = 0; i < 4; i++) if (ack[i]) hit = i;
      checks++;
      if (hit < 0) begin
        errors++; $display("FAIL ack_missing ack=%b gnt=%b", ack, gnt);
      end else if (expq[hit].size() == 0) begin
        errors++; $display("FAIL sb_empty req=%0d wdata=%h", hit, wdata);
      end else begin
        exp_w = expq[hit].pop_front();
        if (wdata !== exp_w) begin
          errors++; $display("FAIL sb_order req=%0d wdata=%h exp=%h", hit, wdata, exp_w);
        end
      end
    end
    @(posedge wclk); #1;
    if (hit >= 0) begin
      seq[hit]++;
      present(hit);
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; req = '0; wfull = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; req = 4'b1111; wfull = 1'b0;
    repeat (2) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc, o_ack, o_wdata} !== 17'h0) begin
        errors++;
        $display("FAIL reset_outputs gnt=%b winc=%b ack=%b wdata=%h exp=all zero",
                 o_gnt, o_winc, o_ack, o_wdata);
      end
    end
    wrst_n = 1'b1; req = '0;
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== 5'b0) begin
      errors++; $display("FAIL reset_idle gnt=%b winc=%b exp=0000/0", o_gnt, o_winc);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== 5'b0) begin
      errors++; $display("FAIL single_grant_cycle gnt=%b winc=%b exp=0000/0", o_gnt, o_winc);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc, o_ack} !== {4'b0001, 1'b1, 4'b0001}) begin
        errors++;
        $display("FAIL single_burst word=%0d gnt=%b winc=%b ack=%b exp=0001/1/0001",
                 k, o_gnt, o_winc, o_ack);
      end
    end
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== 5'b0) begin
      errors++; $display("FAIL single_bubble gnt=%b winc=%b exp=0000/0", o_gnt, o_winc);
    end
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== {4'b0001, 1'b1}) begin
      errors++; $display("FAIL single_regrant gnt=%b winc=%b exp=0001/1", o_gnt, o_winc);
    end
    req = '0;
    cyc();
    cyc();
    checks++;
    if (o_gnt !== 4'b0) begin
      errors++; $display("FAIL single_release gnt=%b exp=0000", o_gnt);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] eg;
    logic       ew;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      ew = (c % 5 != 0);
      eg = ew ? 4'(1 << ((c / 5) % 4)) : 4'b0;
      cyc();
      checks++;
      if ({o_gnt, o_winc, o_ack} !== {eg, ew, ew ? eg : 4'b0}) begin
        errors++;
        $display("FAIL rotate c=%0d gnt=%b winc=%b ack=%b exp=%b/%b", c, o_gnt, o_winc, o_ack, eg, ew);
      end
    end
    req = '0;
    cyc();
  endtask

  task automatic test_stall();
    int w0;
    do_reset();
    req = 4'b0100;
    cyc();
    w0 = words;
    repeat (2) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc} !== {4'b0100, 1'b1}) begin
        errors++; $display("FAIL stall_pre gnt=%b winc=%b exp=0100/1", o_gnt, o_winc);
      end
    end
    wfull = 1'b1;
    repeat (3) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc, o_ack} !== {4'b0100, 1'b0, 4'b0}) begin
        errors++;
        $display("FAIL stall_hold gnt=%b winc=%b ack=%b exp=0100/0/0000", o_gnt, o_winc, o_ack);
      end
    end
    wfull = 1'b0;
    repeat (2) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc} !== {4'b0100, 1'b1}) begin
        errors++; $display("FAIL stall_resume gnt=%b winc=%b exp=0100/1", o_gnt, o_winc);
      end
    end
    cyc();
    checks++;
    if (o_gnt !== 4'b0 || words - w0 != 4) begin
      errors++; $display("FAIL stall_done gnt=%b words=%0d exp=0000/4", o_gnt, words - w0);
    end
    req = '0;
    cyc();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1010;
    cyc();
    repeat (2) begin
      cyc();
      checks++;
      if ({o_gnt, o_winc} !== {4'b0010, 1'b1}) begin
        errors++; $display("FAIL drop_pre gnt=%b winc=%b exp=0010/1", o_gnt, o_winc);
      end
    end
    req = 4'b1000;
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== {4'b0010, 1'b0}) begin
      errors++; $display("FAIL drop_edge gnt=%b winc=%b exp=0010/0", o_gnt, o_winc);
    end
    cyc();
    checks++;
    if (o_gnt !== 4'b0) begin
      errors++; $display("FAIL drop_idle gnt=%b exp=0000", o_gnt);
    end
    cyc();
    checks++;
    if ({o_gnt, o_winc} !== {4'b1000, 1'b1}) begin
      errors++; $display("FAIL drop_next gnt=%b winc=%b exp=1000/1", o_gnt, o_winc);
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    cyc();
    cyc();
    #2;
    checks++;
    if (winc !== 1'b1) begin
      errors++; $display("FAIL arst_pre winc=%b exp=1", winc);
    end
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, winc, ack, wdata} !== 17'h0) begin
      errors++;
      $display("FAIL arst_async gnt=%b winc=%b ack=%b wdata=%h exp=all zero", gnt, winc, ack, wdata);
    end
    req = 4'b1010;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    cyc();
    checks++;
    if (o_gnt !== 4'b0) begin
      errors++; $display("FAIL arst_idle gnt=%b exp=0000", o_gnt);
    end
    cyc();
    checks++;
    if (o_gnt !== 4'b0010) begin
      errors++; $display("FAIL arst_regrant gnt=%b exp=0010", o_gnt);
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_burst1();
    logic ew;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      ew = (c % 2 == 1);
      cyc();
      checks++;
      if ({o_winc1, o_gnt1, o_ack1} !== {ew, ew ? 4'b0001 : 4'b0, ew ? 4'b0001 : 4'b0} ||
          (ew && o_wdata1 !== o_front0)) begin
        errors++;
        $display("FAIL burst1 c=%0d winc=%b gnt=%b ack=%b wdata=%h exp winc=%b wdata=%h",
                 c, o_winc1, o_gnt1, o_ack1, o_wdata1, ew, o_front0);
      end
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_random();
    int w0;
    do_reset();
    w0 = words;
    repeat (400) begin
      req   = 4'($urandom_range(0, 15));
      wfull = ($urandom_range(0, 3) == 0);
      cyc();
    end
    req = '0; wfull = 1'b0;
    repeat (3) cyc();
    checks++;
    if (words - w0 < 50) begin
      errors++; $display("FAIL random_traffic words=%0d exp>=50", words - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      present(i);
    end
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_drop();
    test_async_reset();
    test_burst1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
